// File: rtl/any1_branch_resolve.sv
// any1_branch_resolve: two-stage branch resolver with predictor update, fetch redirect and counters
module any1_eval_branch #(
  parameter int WID = 64
) (
  input  logic [7:0]     op,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  output logic           takb
);
  localparam logic [7:0] OP_BEQ  = 8'h40;
  localparam logic [7:0] OP_BNE  = 8'h41;
  localparam logic [7:0] OP_BLT  = 8'h42;
  localparam logic [7:0] OP_BGE  = 8'h43;
  localparam logic [7:0] OP_BLTU = 8'h44;
  localparam logic [7:0] OP_BGEU = 8'h45;
  always_comb
    takb = (op == OP_BEQ)  ? (a == b) :
           (op == OP_BNE)  ? (a != b) :
           (op == OP_BLT)  ? ($signed(a) <  $signed(b)) :
           (op == OP_BGE)  ? ($signed(a) >= $signed(b)) :
           (op == OP_BLTU) ? (a <  b) :
           (op == OP_BGEU) ? (a >= b) : 1'b0;
endmodule

module any1_branch_resolve #(
  parameter int WID  = 64,
  parameter int RIDW = 5,
  parameter int ILEN = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [63:0]     inst_i,
  input  logic [WID-1:0]  a_i,
  input  logic [WID-1:0]  b_i,
  input  logic [63:0]     pc_i,
  input  logic            pred_taken_i,
  input  logic [63:0]     pred_target_i,
  input  logic [RIDW-1:0] rid_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [RIDW-1:0] out_rid_o,
  output logic            out_taken_o,
  output logic            out_mispredict_o,
  output logic [63:0]     out_npc_o,
  output logic            redirect_o,
  output logic [63:0]     redirect_pc_o,
  output logic            bp_update_o,
  output logic [63:0]     bp_pc_o,
  output logic            bp_taken_o,
  output logic [31:0]     resolved_cnt_o,
  output logic [31:0]     mispred_cnt_o
);
  logic            s1_valid, s1_pt;
  logic [7:0]      s1_op;
  logic [15:0]     s1_disp;
  logic [WID-1:0]  s1_a, s1_b;
  logic [63:0]     s1_pc, s1_ptgt;
  logic [RIDW-1:0] s1_rid;
  logic            s2_valid, s2_taken, s2_mis;
  logic [63:0]     s2_npc, s2_pc;
  logic [RIDW-1:0] s2_rid;
  logic            takb, deliver, squash, s1_move, accept, mis;
  logic [63:0]     target, fallthru;
  logic            unused;
  assign unused = ^inst_i[47:8];
  any1_eval_branch #(.WID(WID)) u_eval (.op(s1_op), .a(s1_a), .b(s1_b), .takb(takb));
  always_comb begin
    target   = s1_pc + {{48{s1_disp[15]}}, s1_disp};
    fallthru = s1_pc + 64'(ILEN);
    mis      = (takb != s1_pt) || (takb && target != s1_ptgt);
    deliver  = s2_valid && out_ready_i;
    squash   = deliver && s2_mis;
    s1_move  = s1_valid && (!s2_valid || out_ready_i);
    in_ready_o = (!s1_valid || s1_move) && !squash;
    accept   = in_valid_i && in_ready_o && !flush_i;
  end
  assign out_valid_o      = s2_valid;
  assign out_rid_o        = s2_rid;
  assign out_taken_o      = s2_taken;
  assign out_mispredict_o = s2_mis;
  assign out_npc_o        = s2_npc;
  assign redirect_o       = deliver && s2_mis;
  assign redirect_pc_o    = s2_npc;
  assign bp_update_o      = deliver;
  assign bp_pc_o          = s2_pc;
  assign bp_taken_o       = s2_taken;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_pt <= 1'b0;
      s1_op <= '0;
      s1_disp <= '0;
      s1_a <= '0;
      s1_b <= '0;
      s1_pc <= '0;
      s1_ptgt <= '0;
      s1_rid <= '0;
      s2_valid <= 1'b0;
      s2_taken <= 1'b0;
      s2_mis <= 1'b0;
      s2_npc <= '0;
      s2_pc <= '0;
      s2_rid <= '0;
      resolved_cnt_o <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (deliver) resolved_cnt_o <= resolved_cnt_o + 32'd1;
      if (deliver && s2_mis) mispred_cnt_o <= mispred_cnt_o + 32'd1;
      if (accept) begin
        s1_op <= inst_i[7:0];
        s1_disp <= inst_i[63:48];
        s1_a <= a_i;
        s1_b <= b_i;
        s1_pc <= pc_i;
        s1_pt <= pred_taken_i;
        s1_ptgt <= pred_target_i;
        s1_rid <= rid_i;
      end
      if (s1_move && !squash) begin
        s2_rid <= s1_rid;
        s2_taken <= takb;
        s2_mis <= mis;
        s2_npc <= takb ? target : fallthru;
        s2_pc <= s1_pc;
      end
      // a delivered mispredict kills the younger entry in S1 instead of moving it
      s1_valid <= !flush_i && (accept || (s1_valid && !s1_move));
      s2_valid <= !flush_i && !squash && (s1_move || (s2_valid && !out_ready_i));
    end
  end
endmodule

// File: tb/tb_any1_branch_resolve.sv
// tb_any1_branch_resolve: directed vectors for the branch resolve stage
module tb_any1_branch_resolve;
  localparam logic [7:0] BEQ = 8'h40, BNE = 8'h41, BLT = 8'h42, BLTU = 8'h44, BGEU = 8'h45;
  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, in_ready, pred_taken = 0;
  logic [63:0] inst = 0, a = 0, b = 0, pc = 0, pred_target = 0;
  logic [4:0]  rid = 0, out_rid;
  logic        out_valid, out_ready = 1, out_taken, out_mis, redirect, bp_update, bp_taken;
  logic [63:0] out_npc, redirect_pc, bp_pc;
  logic [31:0] resolved_cnt, mispred_cnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  any1_branch_resolve dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .a_i(a), .b_i(b), .pc_i(pc), .pred_taken_i(pred_taken),
    .pred_target_i(pred_target), .rid_i(rid), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_rid_o(out_rid), .out_taken_o(out_taken), .out_mispredict_o(out_mis), .out_npc_o(out_npc),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc), .bp_update_o(bp_update), .bp_pc_o(bp_pc),
    .bp_taken_o(bp_taken), .resolved_cnt_o(resolved_cnt), .mispred_cnt_o(mispred_cnt));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic put(input logic v, input logic [7:0] op, input logic [63:0] ta, input logic [63:0] tb,
                     input logic [63:0] tpc, input logic [15:0] disp, input logic pt,
                     input logic [63:0] ptgt, input logic [4:0] trid);
    in_valid = v;
    inst = {disp, 40'h0, op};
    a = ta;
    b = tb;
    pc = tpc;
    pred_taken = pt;
    pred_target = ptgt;
    rid = trid;
  endtask
  task automatic one(input string tag, input logic [7:0] op, input logic [63:0] ta, input logic [63:0] tb,
                     input logic [63:0] tpc, input logic [15:0] disp, input logic pt,
                     input logic [63:0] ptgt, input logic [4:0] trid, input logic et,
                     input logic [63:0] enpc, input logic em, input int eres, input int emis);
    put(1, op, ta, tb, tpc, disp, pt, ptgt, trid);
    @(negedge clk);
    in_valid = 0;
    #1 chk({tag, "_early"}, out_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_rid"}, out_rid, trid);
    chk({tag, "_tkn"}, out_taken, et);
    chk({tag, "_npc"}, out_npc, enpc);
    chk({tag, "_mis"}, out_mis, em);
    chk({tag, "_bpu"}, bp_update, 1);
    chk({tag, "_bppc"}, bp_pc, tpc);
    chk({tag, "_bptk"}, bp_taken, et);
    chk({tag, "_redir"}, redirect, em);
    if (em) chk({tag, "_rpc"}, redirect_pc, enpc);
    @(negedge clk);
    #1;
    chk({tag, "_gone"}, out_valid, 0);
    chk({tag, "_res"}, resolved_cnt, 64'(eres));
    chk({tag, "_mcnt"}, mispred_cnt, 64'(emis));
  endtask
  initial begin
    int idx, ndel;
    logic acc, del;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_res", resolved_cnt, 0);
    chk("rst_mcnt", mispred_cnt, 0);
    chk("rst_redir", redirect, 0);
    chk("rst_bpu", bp_update, 0);
    @(negedge clk);
    one("beq", BEQ, 5, 5, 64'h1000, 16'h0010, 1, 64'h1010, 1, 1, 64'h1010, 0, 1, 0);
    one("blt", BLT, '1, 1, 64'h2000, 16'hFFF0, 0, 0, 2, 1, 64'h1FF0, 1, 2, 1);
    one("bgeu", BGEU, 1, '1, 64'h3000, 16'h0080, 1, 64'h3080, 3, 0, 64'h3008, 1, 3, 2);
    one("bne_tgt", BNE, 1, 2, 64'h4000, 16'h0100, 1, 64'h4200, 4, 1, 64'h4100, 1, 4, 3);
    one("unk", 8'hFF, 0, 0, 64'h5000, 16'h0010, 0, 0, 5, 0, 64'h5008, 0, 5, 3);
    one("wrap", BLTU, 1, 2, 64'hFFFF_FFFF_FFFF_FFF0, 16'h0020, 1, 64'h10, 6, 1, 64'h10, 0, 6, 3);
    @(negedge clk);
    idx = 0;
    ndel = 0;
    for (int c = 0; c < 10; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      if (idx < 4) put(1, BEQ, 64'(idx), 64'(idx), 64'h100 * 64'(idx + 1), 16'h0020, 1,
                       64'h100 * 64'(idx + 1) + 64'h20, 5'(idx + 1));
      else in_valid = 0;
      #1;
      chk("s_rdy", in_ready, (c < 2 || c > 4));
      chk("s_vld", out_valid, (c >= 2 && c <= 8));
      if (out_valid) begin
        chk("s_rid", out_rid, 64'(ndel + 1));
        chk("s_npc", out_npc, 64'h100 * 64'(ndel + 1) + 64'h20);
      end
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      @(negedge clk);
      if (acc) idx++;
      if (del) ndel++;
    end
    chk("s_ndel", 64'(ndel), 4);
    chk("s_res", resolved_cnt, 10);
    out_ready = 0;
    put(1, BEQ, 1, 2, 64'h5000, 16'h0040, 1, 64'h5040, 9);
    @(negedge clk);
    put(1, BEQ, 3, 3, 64'h6000, 16'h0040, 1, 64'h6040, 10);
    @(negedge clk);
    put(1, BEQ, 4, 4, 64'h7000, 16'h0040, 1, 64'h7040, 11);
    #1;
    chk("q_rdy_stall", in_ready, 0);
    chk("q_rid", out_rid, 9);
    chk("q_mis", out_mis, 1);
    @(negedge clk);
    out_ready = 1;
    #1;
    chk("q_rdy_squash", in_ready, 0);
    chk("q_redir", redirect, 1);
    chk("q_rpc", redirect_pc, 64'h5008);
    chk("q_bpu", bp_update, 1);
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("q_vld", out_valid, 0);
    chk("q_rdy", in_ready, 1);
    chk("q_res", resolved_cnt, 11);
    chk("q_mcnt", mispred_cnt, 4);
    @(negedge clk);
    #1 chk("q_vld2", out_valid, 0);
    out_ready = 0;
    put(1, BNE, 1, 1, 64'h8000, 16'h0040, 1, 64'h8040, 12);
    @(negedge clk);
    put(1, BEQ, 2, 2, 64'h9000, 16'h0040, 1, 64'h9040, 13);
    @(negedge clk);
    in_valid = 0;
    flush = 1;
    #1;
    chk("f_full", out_valid, 1);
    chk("f_redir", redirect, 0);
    @(negedge clk);
    flush = 0;
    #1;
    chk("f_vld", out_valid, 0);
    chk("f_rdy", in_ready, 1);
    chk("f_redir2", redirect, 0);
    out_ready = 1;
    @(negedge clk);
    #1;
    chk("f_vld2", out_valid, 0);
    chk("f_res", resolved_cnt, 11);
    out_ready = 0;
    put(1, BNE, 1, 1, 64'hA000, 16'h0040, 1, 64'hA040, 14);
    @(negedge clk);
    put(1, BEQ, 2, 2, 64'hB000, 16'h0040, 1, 64'hB040, 15);
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    #1;
    chk("r_vld", out_valid, 0);
    chk("r_rdy", in_ready, 1);
    chk("r_res", resolved_cnt, 0);
    chk("r_mcnt", mispred_cnt, 0);
    chk("r_redir", redirect, 0);
    @(negedge clk);
    #1 chk("r_vld2", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
